answer_judge: RTL
=================

# answer_judge

Downstream answer stage for the note-memory game. After the playback block has played the stored nibble sequence, this block is armed with that sequence. It then debounces the player's 4-bit key code and checks each accepted press against the expected nibble. It emits `answer`/`answer_enable` in the form the playback block accepts, plus hit/miss/round-done pulses, a timeout flag and a saturating score.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical samples needed to accept a press or a release. Legal range 2..255.
- `TIMEOUT_CYCLES`, default 64: cycles allowed without an accepted press before a timeout miss. Legal range 2..65535.

- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `seq_data`  in  32  note sequence; index i is `seq_data[4i+3:4i]`.
- `seq_last`  in  4  last valid index (playback `max_index`); values >7 are clamped to 7 at arm.
- `arm`  in  1  one-cycle pulse that starts the answer phase.
- `key_code`  in  4  raw player key code; 0 means no key.
- `score_clr`  in  1  pulse that clears `score`.
- `answer`  out  4  accepted key code; held until the next accept.
- `answer_enable`  out  1  one-cycle pulse per accepted press.
- `hit`  out  1  one-cycle pulse: accepted press matched.
- `miss`  out  1  one-cycle pulse: mismatch or timeout.
- `timeout`  out  1  one-cycle pulse, coincident with `miss` on a timeout.
- `round_done`  out  1  one-cycle pulse: the last index was matched.
- `busy`  out  1  high in every state except IDLE.
- `expect_index`  out  4  index currently expected.
- `score`  out  7  completed rounds, saturating at 127.

## Operation
- The state machine has five states: IDLE, WAIT_PRESS, STABLE, WAIT_RELEASE, DONE_RELEASE.
- **IDLE**
  - On `arm`: latch `seq_data` and the clamped `seq_last`, set `expect_index`=0, clear the timer, go to WAIT_PRESS.
  - `arm` in any other state is ignored.
- **WAIT_PRESS**
  - If `key_code`≠0: capture it as the candidate, set the count to 1, go to STABLE.
- **STABLE**
  - If `key_code`≠candidate (including 0): return to WAIT_PRESS. The timer is not cleared.
  - Otherwise the count increments. On the sample that reaches `DEBOUNCE_CYCLES` the press is accepted:
    - `answer`←candidate and `answer_enable` pulses.
    - If candidate = nibble[`expect_index`]:
      - `hit` pulses.
      - If `expect_index`==latched last: `round_done` pulses, `score`+1 (saturating), go to DONE_RELEASE.
      - Otherwise `expect_index`+1 and go to WAIT_RELEASE.
    - If candidate ≠ nibble[`expect_index`]: `miss` pulses and the FSM goes to DONE_RELEASE.
- **WAIT_RELEASE / DONE_RELEASE**
  - Require `DEBOUNCE_CYCLES` consecutive samples of `key_code`==0; any nonzero sample restarts the count.
  - WAIT_RELEASE then clears the timer and goes to WAIT_PRESS.
  - DONE_RELEASE then goes to IDLE; `expect_index` keeps its value.
- **Timer**
  - Increments every cycle in WAIT_PRESS and STABLE; 16-bit.
  - When it reaches `TIMEOUT_CYCLES`-1 without an accept in that same cycle: `miss` and `timeout` pulse and the FSM goes to IDLE.
  - No `answer_enable` is issued on a timeout.
- **Priorities**
  - An accept beats a timeout in the same cycle.
  - `score_clr` beats a simultaneous increment (result 0).
  - `seq_data` and `seq_last` changes after arm have no effect until the next arm.

## Timing
- **Reset:** asserting `reset` at any time, including mid-round, forces IDLE immediately. All outputs go to 0: `answer`, `answer_enable`, `hit`, `miss`, `timeout`, `round_done`, `busy`, `expect_index`, `score`. The timer and debounce counts also clear.
- **`busy`:** goes high in the cycle after the edge that samples `arm`.
- **Accept latency:** a code first sampled at edge E0 and held is accepted at edge E0+`DEBOUNCE_CYCLES`-1.
  - `answer_enable` and `hit`/`miss` are registered pulses, high for exactly the following cycle.
  - `expect_index` and `score` update at that same edge.
- **Release:** the earliest next press is sampled one edge after the release completes.
- **Timeout:** fires `TIMEOUT_CYCLES` edges after entry to WAIT_PRESS, counting from the edge that cleared the timer.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Clean round:** `seq_data`=32'h0000_0321, `seq_last`=2, arm; press 1, 2, 3, each held 6 cycles with 6 zero cycles between.
  - Required: three `answer_enable` pulses with `answer` 1, 2, 3 and three `hit` pulses.
  - `round_done` with the third hit; `score`=1; `busy` low after the final release.
- **Mismatch:** same sequence; press 1, then 4.
  - Required: `hit`, then `miss`, with `answer`=4 and `expect_index`=1.
  - No `round_done`; `score` unchanged; IDLE after release.
- **Bounce:** `key_code` toggles 2,0,2,0 each cycle, then holds 2.
  - Required: no accept during the toggling.
  - Exactly one `answer_enable` pulse, at edge E0+3 measured from the first sample of the steady 2 (`DEBOUNCE_CYCLES`=4).
- **Timeout:** arm with no keys.
  - Required: `miss` and `timeout` high together for one cycle, 64 edges after the arm edge.
  - `answer_enable` never asserted; `busy` drops.
- **Saturation and clear:**
  - Run 128 clean one-note rounds: `score` stops at 127.
  - Assert `score_clr` together with round 129's `round_done`: `score`=0.
- **Reset mid-operation:** assert `reset` while in STABLE with `expect_index`=2.
  - Required: all outputs 0 immediately.
  - `arm` after release restarts at index 0.

Source files
------------

// File: rtl/answer_judge.sv
// answer_judge: debounces the player's key code and checks each accepted press
// against the nibble sequence latched at arm; all outputs are registered.
module answer_judge #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] seq_data,
   input  logic [3:0]  seq_last,
   input  logic        arm,
   input  logic [3:0]  key_code,
   input  logic        score_clr,
   output logic [3:0]  answer,
   output logic        answer_enable,
   output logic        hit,
   output logic        miss,
   output logic        timeout,
   output logic        round_done,
   output logic        busy,
   output logic [3:0]  expect_index,
   output logic [6:0]  score
);

   localparam logic [7:0]  DEB_LIMIT = 8'(DEBOUNCE_CYCLES);
   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      WAIT_PRESS   = 3'd1,
      STABLE       = 3'd2,
      WAIT_RELEASE = 3'd3,
      DONE_RELEASE = 3'd4
   } state_t;

   state_t      state_r;
   state_t      state_nx_s;
   logic [31:0] seq_r;
   logic [2:0]  last_r;
   logic [3:0]  cand_r;
   logic [7:0]  cnt_r;
   logic [7:0]  cnt_nx_s;
   logic [7:0]  cnt_inc_s;
   logic [15:0] timer_r;
   logic [15:0] timer_nx_s;
   logic [3:0]  expected_s;
   logic        key_zero_s;
   logic        key_same_s;
   logic        match_s;
   logic        at_last_s;
   logic        arm_go_s;
   logic        capture_s;
   logic        accept_s;
   logic        tmo_s;
   logic        rel_done_s;
   logic [3:0]  answer_nx_s;
   logic [3:0]  expect_index_nx_s;
   logic [6:0]  score_nx_s;
   logic        answer_enable_nx_s;
   logic        hit_nx_s;
   logic        miss_nx_s;
   logic        timeout_nx_s;
   logic        round_done_nx_s;
   logic        busy_nx_s;

   assign cnt_inc_s  = cnt_r + 8'd1;
   assign key_zero_s = (key_code == 4'd0);
   assign key_same_s = (key_code == cand_r);
   assign expected_s = seq_r[{expect_index[2:0], 2'b00} +: 4];
   assign match_s    = (cand_r == expected_s);
   assign at_last_s  = (expect_index == {1'b0, last_r});
   assign arm_go_s   = (state_r == IDLE) && arm;
   assign capture_s  = (state_r == WAIT_PRESS) && !key_zero_s;
   assign accept_s   = (state_r == STABLE) && key_same_s && (cnt_inc_s == DEB_LIMIT);
   // An accept in the same cycle suppresses the timeout.
   assign tmo_s      = ((state_r == WAIT_PRESS) || (state_r == STABLE)) &&
                       (timer_r == TMO_LAST) && !accept_s;
   assign rel_done_s = ((state_r == WAIT_RELEASE) || (state_r == DONE_RELEASE)) &&
                       key_zero_s && (cnt_inc_s == DEB_LIMIT);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (arm) state_nx_s = WAIT_PRESS;
            else     state_nx_s = IDLE;
         end
         WAIT_PRESS: begin
            if (tmo_s)            state_nx_s = IDLE;
            else if (!key_zero_s) state_nx_s = STABLE;
            else                  state_nx_s = WAIT_PRESS;
         end
         STABLE: begin
            if (accept_s) begin
               if (match_s && !at_last_s) state_nx_s = WAIT_RELEASE;
               else                       state_nx_s = DONE_RELEASE;
            end else if (tmo_s) begin
               state_nx_s = IDLE;
            end else if (!key_same_s) begin
               state_nx_s = WAIT_PRESS;
            end else begin
               state_nx_s = STABLE;
            end
         end
         WAIT_RELEASE: begin
            if (rel_done_s) state_nx_s = WAIT_PRESS;
            else            state_nx_s = WAIT_RELEASE;
         end
         DONE_RELEASE: begin
            if (rel_done_s) state_nx_s = IDLE;
            else            state_nx_s = DONE_RELEASE;
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      answer_enable_nx_s = accept_s;
      hit_nx_s           = accept_s && match_s;
      miss_nx_s          = (accept_s && !match_s) || tmo_s;
      timeout_nx_s       = tmo_s;
      round_done_nx_s    = accept_s && match_s && at_last_s;
      busy_nx_s          = (state_nx_s != IDLE);
      if (accept_s) answer_nx_s = cand_r;
      else          answer_nx_s = answer;
      if (arm_go_s)                                 expect_index_nx_s = 4'd0;
      else if (accept_s && match_s && !at_last_s)   expect_index_nx_s = expect_index + 4'd1;
      else                                          expect_index_nx_s = expect_index;
      if (score_clr)                                score_nx_s = 7'd0;
      else if (round_done_nx_s && score != 7'd127)  score_nx_s = score + 7'd1;
      else                                          score_nx_s = score;
   end

   // Debounce count and inactivity timer.
   always_comb begin
      cnt_nx_s   = cnt_r;
      timer_nx_s = timer_r;
      case (state_r)
         IDLE: begin
            cnt_nx_s = 8'd0;
            if (arm_go_s) timer_nx_s = 16'd0;
            else          timer_nx_s = timer_r;
         end
         WAIT_PRESS, STABLE: begin
            if (capture_s)                     cnt_nx_s = 8'd1;
            else if (accept_s)                 cnt_nx_s = 8'd0;
            else if (state_r == STABLE && key_same_s) cnt_nx_s = cnt_inc_s;
            else                               cnt_nx_s = cnt_r;
            if (tmo_s) timer_nx_s = 16'd0;
            else       timer_nx_s = timer_r + 16'd1;
         end
         WAIT_RELEASE, DONE_RELEASE: begin
            if (!key_zero_s || rel_done_s) cnt_nx_s = 8'd0;
            else                           cnt_nx_s = cnt_inc_s;
            if (rel_done_s && state_r == WAIT_RELEASE) timer_nx_s = 16'd0;
            else                                       timer_nx_s = timer_r;
         end
         default: begin
            cnt_nx_s   = 8'd0;
            timer_nx_s = 16'd0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seq_r         <= 32'd0;
         last_r        <= 3'd0;
         cand_r        <= 4'd0;
         cnt_r         <= 8'd0;
         timer_r       <= 16'd0;
         answer        <= 4'd0;
         answer_enable <= 1'b0;
         hit           <= 1'b0;
         miss          <= 1'b0;
         timeout       <= 1'b0;
         round_done    <= 1'b0;
         busy          <= 1'b0;
         expect_index  <= 4'd0;
         score         <= 7'd0;
      end else begin
         if (arm_go_s) begin
            seq_r  <= seq_data;
            last_r <= (seq_last > 4'd7) ? 3'd7 : seq_last[2:0];
         end
         if (capture_s) cand_r <= key_code;
         cnt_r         <= cnt_nx_s;
         timer_r       <= timer_nx_s;
         answer        <= answer_nx_s;
         answer_enable <= answer_enable_nx_s;
         hit           <= hit_nx_s;
         miss          <= miss_nx_s;
         timeout       <= timeout_nx_s;
         round_done    <= round_done_nx_s;
         busy          <= busy_nx_s;
         expect_index  <= expect_index_nx_s;
         score         <= score_nx_s;
      end
   end

endmodule
